// File: rtl/i2c_byte_engine.sv
// i2c_byte_engine: I2C master bit/byte sequencer turning START/STOP/WRITE/READ commands into
// open-drain SCL/SDA drive on quarter-bit strobes, with ACK sampling and arbitration-loss detection.
module i2c_byte_engine #(
  parameter int SYNC_STAGES = 2,
  parameter bit ARB_CHECK   = 1'b1
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic [1:0] phase_i,
  input  logic       phase_inc_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [7:0] cmd_data_i,
  input  logic       cmd_ack_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_ack_o,
  output logic       rsp_arb_lost_o,
  output logic       bus_active_o,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  input  logic       scl_i,
  input  logic       sda_i
);
  localparam logic [1:0] C_START = 2'd0, C_STOP = 2'd1, C_WRITE = 2'd2, C_READ = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} state_t;
  state_t r_state, w_state;
  logic [1:0] r_cmd, w_cmd;
  logic [7:0] r_wdata, w_wdata, r_rsh, w_rsh, r_rsp_data, w_rsp_data;
  logic [3:0] r_bit, w_bit;
  logic r_rack, w_rack, r_sample, w_sample, r_rsp_valid, w_rsp_valid, r_rsp_ack, w_rsp_ack;
  logic r_arb, w_arb, r_bus, w_bus, r_scl_oe, w_scl_oe, r_sda_oe, w_sda_oe;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic w_scl, w_sda, w_slot, w_last, w_cur_bit, w_arb_hit;
  assign w_scl     = r_scl_sync[SYNC_STAGES-1];
  assign w_sda     = r_sda_sync[SYNC_STAGES-1];
  assign w_slot    = phase_inc_i & (phase_i == 2'd0);
  assign w_last    = r_cmd[1] ? (r_bit == 4'd8) : 1'b1;
  assign w_cur_bit = r_wdata[~r_bit[2:0]];
  // SDA is only meaningful while SCL is high, so a loss needs our released bit read low with SCL up
  assign w_arb_hit = ARB_CHECK && r_state == S_RUN && r_cmd == C_WRITE && !r_bit[3] && w_cur_bit &&
                     !w_sda && w_scl && phase_inc_i && phase_i == 2'd3;
  always_comb begin
    w_state     = r_state;
    w_cmd       = r_cmd;
    w_wdata     = r_wdata;
    w_rack      = r_rack;
    w_bit       = r_bit;
    w_rsh       = r_rsh;
    w_sample    = r_sample;
    w_rsp_valid = 1'b0;
    w_rsp_data  = r_rsp_data;
    w_rsp_ack   = r_rsp_ack;
    w_arb       = 1'b0;
    w_bus       = r_bus;
    w_scl_oe    = r_scl_oe;
    w_sda_oe    = r_sda_oe;
    if (r_state == S_IDLE && cmd_valid_i) begin
      w_state = S_WAIT;
      w_cmd   = cmd_i;
      w_wdata = cmd_data_i;
      w_rack  = cmd_ack_i;
    end
    if (r_state == S_WAIT && w_slot) begin
      w_state = S_RUN;
      w_bit   = 4'd0;
    end
    if (r_state == S_RUN && w_slot) begin
      if (w_last) begin
        w_state     = S_IDLE;
        w_bit       = 4'd0;
        w_rsp_valid = 1'b1;
        w_rsp_ack   = (r_cmd == C_WRITE) & ~r_sample;
        w_rsp_data  = (r_cmd == C_READ) ? r_rsh : r_rsp_data;
        w_bus       = (r_cmd == C_START) ? 1'b1 : (r_cmd == C_STOP) ? 1'b0 : r_bus;
        w_scl_oe    = w_bus;
        w_sda_oe    = w_bus & r_sda_oe;
      end else begin
        w_bit = r_bit + 4'd1;
      end
    end
    if (r_state == S_RUN && phase_inc_i && phase_i == 2'd3 && r_cmd[1]) begin
      w_rsh    = (r_cmd == C_READ && !r_bit[3]) ? {r_rsh[6:0], w_sda} : r_rsh;
      w_sample = r_bit[3] ? w_sda : r_sample;
    end
    if (w_state == S_RUN && phase_inc_i) begin
      w_scl_oe = (r_cmd == C_START) ? (phase_i == 2'd0) & r_bus :
                 (r_cmd == C_STOP)  ? (phase_i == 2'd0) : ~phase_i[1];
      w_sda_oe = (r_cmd == C_START) ? phase_i[1] :
                 (r_cmd == C_STOP)  ? (phase_i != 2'd3) :
                 (r_cmd == C_WRITE) ? ~w_bit[3] & ~r_wdata[~w_bit[2:0]] : w_bit[3] & r_rack;
    end
    if (w_arb_hit) begin
      w_state     = S_IDLE;
      w_bit       = 4'd0;
      w_rsp_valid = 1'b1;
      w_arb       = 1'b1;
      w_rsp_ack   = 1'b0;
      w_bus       = 1'b0;
      w_scl_oe    = 1'b0;
      w_sda_oe    = 1'b0;
    end
  end
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= S_IDLE;
      r_cmd       <= 2'd0;
      r_wdata     <= 8'd0;
      r_rack      <= 1'b0;
      r_bit       <= 4'd0;
      r_rsh       <= 8'd0;
      r_sample    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'd0;
      r_rsp_ack   <= 1'b0;
      r_arb       <= 1'b0;
      r_bus       <= 1'b0;
      r_scl_oe    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_scl_sync  <= '1;
      r_sda_sync  <= '1;
    end else begin
      r_state     <= w_state;
      r_cmd       <= w_cmd;
      r_wdata     <= w_wdata;
      r_rack      <= w_rack;
      r_bit       <= w_bit;
      r_rsh       <= w_rsh;
      r_sample    <= w_sample;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_data  <= w_rsp_data;
      r_rsp_ack   <= w_rsp_ack;
      r_arb       <= w_arb;
      r_bus       <= w_bus;
      r_scl_oe    <= w_scl_oe;
      r_sda_oe    <= w_sda_oe;
      r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
    end
  end
  assign cmd_ready_o    = (r_state == S_IDLE);
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_data_o     = r_rsp_data;
  assign rsp_ack_o      = r_rsp_ack;
  assign rsp_arb_lost_o = r_arb;
  assign bus_active_o   = r_bus;
  assign scl_oe_o       = r_scl_oe;
  assign sda_oe_o       = r_sda_oe;
endmodule

// File: tb/tb_i2c_byte_engine.sv
// tb_i2c_byte_engine: random command stream against a slot/quarter table model of the I2C engine,
// with a bus-level slave and directed literal checks.
module tb_i2c_byte_engine;
  localparam int Q = 8;
  localparam logic [1:0] START = 2'd0, STOP = 2'd1, WRITE = 2'd2, READ = 2'd3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] phase = 2'd0, cmd = 2'd0;
  logic inc = 1'b0, valid = 1'b0, ack = 1'b0, slave_pull = 1'b0;
  logic [7:0] data = 8'd0;
  logic ready, rsp_valid, rsp_ack, arb_lost, bus_active, scl_oe, sda_oe, scl_line, sda_line;
  logic [7:0] rsp_data;
  assign scl_line = ~scl_oe;
  assign sda_line = ~(sda_oe | slave_pull);
  always #5 clk = ~clk;
  i2c_byte_engine dut (
    .clock_i(clk), .reset_n_i(rst_n), .phase_i(phase), .phase_inc_i(inc),
    .cmd_valid_i(valid), .cmd_ready_o(ready), .cmd_i(cmd), .cmd_data_i(data), .cmd_ack_i(ack),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_ack_o(rsp_ack), .rsp_arb_lost_o(arb_lost),
    .bus_active_o(bus_active), .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .scl_i(scl_line), .sda_i(sda_line)
  );
  int total = 0, bad = 0, n_rsp = 0;
  int m_mode = 0, k = 0, nq = 0;
  logic m_scl_seq [36], m_sda_seq [36], c_scl [36], c_sda [36];
  logic [1:0] m_cmd = 2'd0;
  logic [7:0] m_data = 8'd0, m_rsh = 8'd0, e_rdata = 8'd0, s_byte = 8'd0;
  logic m_ack = 0, m_bus = 0, m_samp9 = 0, e_scl = 0, e_sda = 0, e_rsp = 0, e_arb = 0, e_ack = 0, s_ack = 0;
  int s_arb_bit = -1;
  logic last_ack, last_arb;
  logic [7:0] last_data;
  initial begin
    int pcnt;
    pcnt = 0;
    forever begin
      @(negedge clk);
      if (pcnt == Q - 1) begin pcnt = 0; phase = phase + 2'd1; inc = 1'b1; end
      else begin pcnt++; inc = 1'b0; end
    end
  end
  // quarter-by-quarter drive table for one command, straight from the bus waveform definitions
  task automatic build();
    nq = m_cmd[1] ? 36 : 4;
    for (int q = 0; q < nq; q++) begin
      int s, p;
      s = q / 4; p = q % 4;
      if (m_cmd == START) begin m_scl_seq[q] = (p == 0) && m_bus; m_sda_seq[q] = (p >= 2); end
      else if (m_cmd == STOP) begin m_scl_seq[q] = (p == 0); m_sda_seq[q] = (p != 3); end
      else begin
        m_scl_seq[q] = (p < 2);
        if (m_cmd == WRITE) m_sda_seq[q] = (s < 8) ? !m_data[7 - s] : 1'b0;
        else m_sda_seq[q] = (s == 8) ? m_ack : 1'b0;
      end
    end
  endtask
  initial begin
    forever begin
      logic line;
      logic [14:0] got, exp;
      @(posedge clk);
      if (!rst_n) begin
        m_mode = 0; k = 0; m_bus = 0; m_rsh = 0; m_samp9 = 0;
        e_scl = 0; e_sda = 0; e_rsp = 0; e_arb = 0; e_ack = 0; e_rdata = 0;
      end else begin
        e_rsp = 0; e_arb = 0;
        line = !(e_sda | slave_pull);
        if (m_mode == 0) begin
          if (valid) begin m_cmd = cmd; m_data = data; m_ack = ack; m_mode = 1; end
        end else if (m_mode == 1) begin
          if (inc && phase == 2'd0) begin
            build(); k = 0; m_mode = 2; e_scl = m_scl_seq[0]; e_sda = m_sda_seq[0];
          end
        end else if (inc) begin
          if (phase == 2'd0 && k == nq - 1) begin
            m_mode = 0; e_rsp = 1;
            e_ack = (m_cmd == WRITE) ? !m_samp9 : 1'b0;
            if (m_cmd == READ) e_rdata = m_rsh;
            if (m_cmd == START) m_bus = 1;
            if (m_cmd == STOP) m_bus = 0;
            e_scl = m_bus; e_sda = m_bus & e_sda;
          end else begin
            k++;
            e_scl = m_scl_seq[k]; e_sda = m_sda_seq[k];
            if (phase == 2'd3 && m_cmd[1]) begin
              if (k / 4 == 8) m_samp9 = line;
              else if (m_cmd == READ) m_rsh = {m_rsh[6:0], line};
              else if (m_data[7 - k / 4] && !line) begin
                m_mode = 0; e_rsp = 1; e_arb = 1; e_ack = 0; m_bus = 0; e_scl = 0; e_sda = 0;
              end
            end
          end
        end
      end
      #1;
      got = {ready, rsp_valid, arb_lost, bus_active, scl_oe, sda_oe, rsp_ack, rsp_data};
      exp = {m_mode == 0, e_rsp, e_arb, m_bus, e_scl, e_sda, e_ack, e_rdata};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL cycle t=%0t got rdy/vld/arb/bus/scl/sda/ack/data=%b exp=%b", $time, got, exp);
      end
      if (m_mode == 2) begin c_scl[k] = scl_oe; c_sda[k] = sda_oe; end
      if (rsp_valid) n_rsp++;
      if (m_mode == 2 && m_cmd == WRITE) slave_pull = (k / 4 == 8 && s_ack) || (k / 4 == s_arb_bit);
      else if (m_mode == 2 && m_cmd == READ) slave_pull = (k / 4 < 8) && !s_byte[7 - k / 4];
      else slave_pull = 0;
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s got=%h exp=%h", name, got, exp); end
  endtask
  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic a);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 5000) begin @(negedge clk); n++; end
    chk("ready_wait", ready, 1);
    valid = 1; cmd = c; data = d; ack = a;
    @(negedge clk);
    valid = 0; cmd = 2'($urandom); data = 8'($urandom); ack = 1'($urandom);
  endtask
  task automatic send(input logic [1:0] c, input logic [7:0] d, input logic a);
    int n;
    issue(c, d, a);
    n = 0;
    while (!rsp_valid && n < 3000) begin
      valid = !ready && $urandom_range(7) == 0;
      if (valid) begin cmd = 2'($urandom); data = 8'($urandom); ack = 1'($urandom); end
      @(negedge clk);
      n++;
    end
    valid = 0;
    chk("rsp_wait", rsp_valid, 1);
    last_ack = rsp_ack; last_arb = arb_lost; last_data = rsp_data;
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int r0;
    logic [7:0] cap;
    repeat (3) @(negedge clk);
    chk("reset_state", {ready, rsp_valid, arb_lost, bus_active, scl_oe, sda_oe, rsp_ack, rsp_data}, 15'h4000);
    rst_n = 1;
    repeat (5) @(negedge clk);
    r0 = n_rsp;
    send(START, 8'h00, 0);
    repeat (40) @(negedge clk);
    chk("start_bus", bus_active, 1);
    chk("start_scl", {c_scl[0], c_scl[1], c_scl[2], c_scl[3]}, 0);
    chk("start_sda", {c_sda[0], c_sda[1], c_sda[2], c_sda[3]}, 4'b0011);
    chk("start_pulses", n_rsp - r0, 1);
    s_ack = 1;
    send(WRITE, 8'hA5, 0);
    for (int s = 0; s < 8; s++) cap[7 - s] = c_sda[4 * s + 1];
    chk("wr_sda_bits", cap, 8'h5A);
    chk("wr_ack", last_ack, 1);
    chk("wr_arb", last_arb, 0);
    s_byte = 8'h3C;
    r0 = n_rsp;
    send(READ, 8'h00, 0);
    repeat (40) @(negedge clk);
    chk("rd_data", last_data, 8'h3C);
    chk("rd_bit9_sda", {c_sda[32], c_sda[33], c_sda[34], c_sda[35]}, 0);
    chk("rd_pulses", n_rsp - r0, 1);
    send(WRITE, 8'h12, 0);
    send(STOP, 8'h00, 0);
    chk("stop_p2p3", {c_scl[2], c_sda[2], c_scl[3], c_sda[3]}, 4'b0100);
    chk("stop_bus_ready", {bus_active, ready}, 2'b01);
    send(START, 8'h00, 0);
    s_ack = 0; s_arb_bit = 2;
    send(WRITE, 8'hFF, 0);
    chk("arb_out", {arb_lost, scl_oe, sda_oe, bus_active, rsp_ack}, 5'b10000);
    s_arb_bit = -1;
    for (int it = 0; it < 25; it++) begin
      int n;
      send(START, 8'h00, 0);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        s_ack = 1'($urandom); s_byte = 8'($urandom);
        s_arb_bit = ($urandom_range(5) == 0) ? int'($urandom_range(7)) : -1;
        send($urandom_range(1) ? WRITE : READ, 8'($urandom), 1'($urandom));
        if (last_arb) break;
      end
      s_arb_bit = -1;
      if ($urandom_range(2) != 0) send(STOP, 8'h00, 0);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    send(START, 8'h00, 0);
    s_byte = 8'h81;
    issue(READ, 8'h00, 1);
    begin
      int n;
      n = 0;
      while (!(m_mode == 2 && k == 17) && n < 3000) begin @(negedge clk); n++; end
    end
    chk("rst_pre_scl", scl_oe, 1);
    r0 = n_rsp;
    #2 rst_n = 0;
    #1 chk("rst_drive", {scl_oe, sda_oe}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1 chk("rst_ready", ready, 1);
    repeat (40) @(negedge clk);
    chk("rst_no_rsp", n_rsp - r0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
